alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_iter.sv | 52 +++++
 rtl/alu_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit positions and sequencer states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOT   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_INC   = 4'h8,
    OP_DEC   = 4'h9,
    OP_PASSA = 4'hA,
    OP_PASSB = 4'hB,
    OP_MUL   = 4'hC
  } alu_op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle for WIDTH cycles.
// done_o is combinational on the last step; product_o carries that step's sum.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  always_comb begin
    acc_nxt   = acc + (mplier[0] ? mcand : '0);
    done_o    = busy_o && (cnt == CW'(WIDTH - 1));
    product_o = acc_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start_i) begin
      busy_o <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a_i};
      mplier <= b_i;
    end else if (busy_o) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done_o) busy_o <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with Z/N/C/V flags; single-cycle ops have latency 1, MUL (ALU_SEQ_MUL_EN) takes WIDTH cycles.
// No output backpressure; while a MUL runs ready_o is low and requests are dropped.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic [3:0]       flags_o
);

  alu_op_e          op;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             c_flag;
  logic             v_flag;
  logic             upd_flags;
  logic             is_mul;
  logic [3:0]       flags_nxt;

  assign op     = alu_op_e'(op_i);
  assign accept = valid_i && ready_o;

  // INC/DEC reuse the shared adder/subtractor with an implicit operand of one
  assign b_eff = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : b_i;
  assign sum   = {1'b0, a_i} + {1'b0, b_eff};
  assign diff  = {1'b0, a_i} - {1'b0, b_eff};

  always_comb begin
    res       = '0;
    c_flag    = 1'b0;
    v_flag    = 1'b0;
    upd_flags = 1'b1;
    is_mul    = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        res    = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        res    = diff[WIDTH-1:0];
        c_flag = diff[WIDTH];
        v_flag = (a_i[WIDTH-1] != b_eff[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:   res = a_i & b_i;
      OP_OR:    res = a_i | b_i;
      OP_XOR:   res = a_i ^ b_i;
      OP_NOT:   res = ~a_i;
      OP_SHL: begin
        res    = a_i << 1;
        c_flag = a_i[WIDTH-1];
      end
      OP_SHR: begin
        res    = a_i >> 1;
        c_flag = a_i[0];
      end
      OP_PASSA: res = a_i;
      OP_PASSB: res = b_i;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        is_mul    = 1'b1;
        upd_flags = 1'b0;
      end
`endif
      default:  upd_flags = 1'b0;
    endcase
  end

  always_comb begin
    flags_nxt         = '0;
    flags_nxt[FLAG_Z] = (res == '0);
    flags_nxt[FLAG_N] = res[WIDTH-1];
    flags_nxt[FLAG_C] = c_flag;
    flags_nxt[FLAG_V] = v_flag;
  end

`ifdef ALU_SEQ_MUL_EN
  alu_state_e         state;
  alu_state_e         state_nxt;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_res;
  logic [3:0]         mul_flags;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (accept && is_mul),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (accept && is_mul) state_nxt = MUL_RUN;
      end
      MUL_RUN: begin
        if (mul_done || !mul_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Carry reports any overflow of the product into the discarded high half
  always_comb begin
    mul_res           = mul_prod[WIDTH-1:0];
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_res == '0);
    mul_flags[FLAG_N] = mul_res[WIDTH-1];
    mul_flags[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_V] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o <= '0;
      flags_o  <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (state == MUL_RUN && mul_done) begin
        result_o <= mul_res;
        flags_o  <= mul_flags;
        valid_o  <= 1'b1;
      end else if (accept && !is_mul) begin
        result_o <= res;
        if (upd_flags) flags_o <= flags_nxt;
        valid_o  <= 1'b1;
      end
    end
  end
`else
  assign ready_o = 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o <= '0;
      flags_o  <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept && !is_mul) begin
        result_o <= res;
        if (upd_flags) flags_o <= flags_nxt;
        valid_o  <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors plus randomized ops against an arithmetic reference model.
module tb_alu_seq;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] a_i, b_i;
  logic [3:0] op_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] result_o;
  logic       valid_o;
  logic [3:0] flags_o;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_res = '0;
  logic [3:0] exp_flags = '0;

  alu_seq #(.WIDTH(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .op_i     (op_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .result_o (result_o),
    .valid_o  (valid_o),
    .flags_o  (flags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input int op, input int a, input int b);
    valid_i = v;
    op_i    = 4'(op);
    a_i     = 8'(a);
    b_i     = 8'(b);
  endtask

  function automatic int to_signed(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference: plain integer arithmetic on the op semantics
  function automatic void model(input int op, input int a, input int b,
                                output logic [7:0] r, output logic [3:0] f, output bit upd);
    int full, sfull, c, v, rr;
    c = 0; v = 0; rr = 0; upd = 1;
    case (op)
      0:  begin full = a + b;  sfull = to_signed(a) + to_signed(b); rr = full % 256;
                c = (full > 255); v = (sfull > 127 || sfull < -128); end
      1:  begin sfull = to_signed(a) - to_signed(b); rr = (a - b + 256) % 256;
                c = (a < b); v = (sfull > 127 || sfull < -128); end
      2:  rr = a & b;
      3:  rr = a | b;
      4:  rr = a ^ b;
      5:  rr = 255 - a;
      6:  begin rr = (a * 2) % 256; c = (a >= 128); end
      7:  begin rr = a / 2; c = a % 2; end
      8:  begin full = a + 1; sfull = to_signed(a) + 1; rr = full % 256;
                c = (full > 255); v = (sfull > 127); end
      9:  begin sfull = to_signed(a) - 1; rr = (a + 255) % 256;
                c = (a == 0); v = (sfull < -128); end
      10: rr = a;
      11: rr = b;
`ifdef ALU_SEQ_MUL_EN
      12: begin full = a * b; rr = full % 256; c = (full > 255); end
`endif
      default: begin rr = 0; upd = 0; end
    endcase
    r = 8'(rr);
    f = {rr == 0, rr >= 128, c != 0, v != 0};
  endfunction

  function automatic int pick_operand();
    int sel;
    int edges[5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    sel = $urandom_range(0, 7);
    if (sel < 5 && $urandom_range(0, 1) == 1) return edges[sel];
    return $urandom_range(0, 255);
  endfunction

  task automatic test_reset;
    rst_i = 1'b1;
    drive(1'b0, 0, 0, 0);
    tick;
    tick;
    rst_i = 1'b0;
    checks++; if (result_o !== 8'h00) begin failures++; $display("FAIL reset_result got=%h want=00", result_o); end
    checks++; if (flags_o !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", flags_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    exp_res = '0; exp_flags = '0;
  endtask

  task automatic test_directed;
    // ADD overflow into sign bit
    drive(1'b1, 0, 8'h7F, 8'h01);
    tick;
    drive(1'b0, 0, 0, 0);
    checks++; if (result_o !== 8'h80 || flags_o !== 4'b0101 || valid_o !== 1'b1) begin
      failures++; $display("FAIL add_7f_01 got=%h/%b/%b want=80/0101/1", result_o, flags_o, valid_o); end
    tick;
    checks++; if (valid_o !== 1'b0 || result_o !== 8'h80) begin
      failures++; $display("FAIL add_pulse got=%b/%h want=0/80", valid_o, result_o); end
    // two SUBs back-to-back
    drive(1'b1, 1, 8'h05, 8'h05);
    tick;
    checks++; if (result_o !== 8'h00 || flags_o !== 4'b1000 || valid_o !== 1'b1) begin
      failures++; $display("FAIL sub_5_5 got=%h/%b/%b want=00/1000/1", result_o, flags_o, valid_o); end
    drive(1'b1, 1, 8'h03, 8'h05);
    tick;
    checks++; if (result_o !== 8'hFE || flags_o !== 4'b0110 || valid_o !== 1'b1) begin
      failures++; $display("FAIL sub_3_5 got=%h/%b/%b want=FE/0110/1", result_o, flags_o, valid_o); end
    drive(1'b1, 7, 8'h01, 8'hAA);
    tick;
    checks++; if (result_o !== 8'h00 || flags_o !== 4'b1010 || valid_o !== 1'b1) begin
      failures++; $display("FAIL shr_01 got=%h/%b/%b want=00/1010/1", result_o, flags_o, valid_o); end
    drive(1'b1, 11, 8'h5A, 8'h00);
    tick;
    checks++; if (result_o !== 8'h00 || flags_o !== 4'b1000 || valid_o !== 1'b1) begin
      failures++; $display("FAIL passb_00 got=%h/%b/%b want=00/1000/1", result_o, flags_o, valid_o); end
    drive(1'b0, 0, 0, 0);
    tick;
    exp_res = 8'h00; exp_flags = 4'b1000;
  endtask

  task automatic test_random_single;
    logic [7:0] r;
    logic [3:0] f;
    bit upd, v, exp_v;
    int op, a, b;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      op = $urandom_range(0, 15);
`ifdef ALU_SEQ_MUL_EN
      if (op == 12) op = 10;
`endif
      a = pick_operand();
      b = pick_operand();
      drive(v, op, a, b);
      exp_v = v;
      if (v) begin
        model(op, a, b, r, f, upd);
        exp_res = r;
        if (upd) exp_flags = f;
      end
      tick;
      checks++; if (valid_o !== exp_v) begin failures++; $display("FAIL rand_valid i=%0d op=%0d got=%b want=%b", i, op, valid_o, exp_v); end
      checks++; if (result_o !== exp_res) begin failures++; $display("FAIL rand_result i=%0d op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, result_o, exp_res); end
      checks++; if (flags_o !== exp_flags) begin failures++; $display("FAIL rand_flags i=%0d op=%0d a=%h b=%h got=%b want=%b", i, op, a, b, flags_o, exp_flags); end
      checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rand_ready i=%0d got=%b want=1", i, ready_o); end
    end
    drive(1'b0, 0, 0, 0);
    tick;
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic run_mul(input int a, input int b, input string name);
    logic [7:0] r;
    logic [3:0] f;
    bit upd;
    model(12, a, b, r, f, upd);
    drive(1'b1, 12, a, b);
    tick;
    for (int i = 0; i < 8; i++) begin
      checks++; if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
        failures++; $display("FAIL %s_busy cyc=%0d got ready=%b valid=%b want 0/0", name, i, ready_o, valid_o); end
      // requests and operand changes during the run must be ignored
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 11), $urandom_range(0, 255), $urandom_range(0, 255));
      tick;
    end
    drive(1'b0, 0, 0, 0);
    checks++; if (valid_o !== 1'b1 || ready_o !== 1'b1) begin
      failures++; $display("FAIL %s_done got valid=%b ready=%b want 1/1", name, valid_o, ready_o); end
    checks++; if (result_o !== r || flags_o !== f) begin
      failures++; $display("FAIL %s_value a=%h b=%h got=%h/%b want=%h/%b", name, a, b, result_o, flags_o, r, f); end
    exp_res = r; exp_flags = f;
    tick;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL %s_pulse got=%b want=0", name, valid_o); end
  endtask

  task automatic test_mul;
    run_mul(8'h10, 8'h11, "mul_10_11");
    checks++; if (result_o !== 8'h10 || flags_o !== 4'b0010) begin
      failures++; $display("FAIL mul_10_11_lit got=%h/%b want=10/0010", result_o, flags_o); end
    for (int i = 0; i < 12; i++) run_mul(pick_operand(), pick_operand(), "mul_rand");
  endtask

  task automatic test_reset_mid_mul;
    drive(1'b1, 12, 8'hFF, 8'hFF);
    tick;
    drive(1'b0, 0, 0, 0);
    tick; tick; tick;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    checks++; if (result_o !== 8'h00 || flags_o !== 4'b0000 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++; $display("FAIL mulrst_out got=%h/%b/%b/%b want=00/0000/0/1", result_o, flags_o, valid_o, ready_o); end
    drive(1'b1, 0, 8'h12, 8'h34);
    tick;
    drive(1'b0, 0, 0, 0);
    checks++; if (result_o !== 8'h46 || flags_o !== 4'b0000 || valid_o !== 1'b1) begin
      failures++; $display("FAIL mulrst_add got=%h/%b/%b want=46/0000/1", result_o, flags_o, valid_o); end
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++; if (valid_o !== 1'b0 || result_o !== 8'h46 || ready_o !== 1'b1) begin
        failures++; $display("FAIL mulrst_abort cyc=%0d got=%b/%h/%b want=0/46/1", i, valid_o, result_o, ready_o); end
    end
  endtask
`else
  task automatic test_mul_reserved;
    drive(1'b1, 1, 8'h03, 8'h05);
    tick;
    drive(1'b1, 12, 8'h10, 8'h11);
    tick;
    drive(1'b0, 0, 0, 0);
    checks++; if (result_o !== 8'h00 || flags_o !== 4'b0110 || valid_o !== 1'b1 || ready_o !== 1'b1) begin
      failures++; $display("FAIL opc_reserved got=%h/%b/%b/%b want=00/0110/1/1", result_o, flags_o, valid_o, ready_o); end
    tick;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++; $display("FAIL opc_pulse got=%b/%b want=0/1", valid_o, ready_o); end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 5, 8'h00, 8'h00);
    tick;
    drive(1'b1, 0, 8'h22, 8'h11);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    drive(1'b0, 0, 0, 0);
    checks++; if (result_o !== 8'h00 || flags_o !== 4'b0000 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++; $display("FAIL rst_mid got=%h/%b/%b/%b want=00/0000/0/1", result_o, flags_o, valid_o, ready_o); end
  endtask
`endif

  task automatic test_hold;
    drive(1'b1, 9, 8'h00, 8'h00);
    tick;
    checks++; if (result_o !== 8'hFF || flags_o !== 4'b0110 || valid_o !== 1'b1) begin
      failures++; $display("FAIL dec_00 got=%h/%b/%b want=FF/0110/1", result_o, flags_o, valid_o); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, $urandom_range(0, 11), $urandom_range(0, 255), $urandom_range(0, 255));
      tick;
      checks++; if (valid_o !== 1'b0 || result_o !== 8'hFF || flags_o !== 4'b0110) begin
        failures++; $display("FAIL hold cyc=%0d got=%b/%h/%b want=0/FF/0110", i, valid_o, result_o, flags_o); end
    end
  endtask

  initial begin
    rst_i = 1'b0;
    drive(1'b0, 0, 0, 0);
    test_reset;
    test_directed;
    test_hold;
    test_random_single;
`ifdef ALU_SEQ_MUL_EN
    test_mul;
    test_reset_mid_mul;
`else
    test_mul_reserved;
    test_reset_midstream;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
